i2s_dac_tx: RTL

Stereo I2S transmitter that streams 16-bit PCM to the WM8731 codec once the I2C configuration sequencer has programmed it for I2S, 16-bit, slave mode, normal-mode 48 kHz with the internal oscillator powered down. It sits between the core's audio mixer and the codec pins. It generates the codec master clock, bit clock, DAC LR clock and serial data, and pulls samples from the mixer through a one-entry valid/ready buffer.

---
 rtl/i2s_dac_tx_pkg.sv | 16 +
 rtl/clk_half_div.sv | 33 +++
 rtl/i2s_dac_tx.sv | 126 ++++++++++++
 3 files changed

// File: rtl/i2s_dac_tx_pkg.sv
// Shared audio types and frame geometry for the I2S DAC path.
// Sample pairs travel as a packed {l,r} struct from the mixer to the shifter.
package i2s_dac_tx_pkg;
  localparam int SAMPLE_W    = 16;
  localparam int SLOT_BCLKS  = 32;
  localparam int FRAME_BCLKS = 64;
  localparam int CNT_W       = $clog2(FRAME_BCLKS);
  localparam int SLOT_W      = $clog2(SLOT_BCLKS);

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;
endpackage

// File: rtl/clk_half_div.sv
// Free-running divider: toggles oCLK every HDIV iCLK cycles.
// oTGL is high in the cycle whose closing edge flips oCLK.
module clk_half_div #(
  parameter int HDIV = 1
) (
  input  logic iCLK,
  input  logic iRST_N,
  output logic oCLK,
  output logic oTGL
);
  localparam int CW = (HDIV > 1) ? $clog2(HDIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_q, clk_d;

  always_comb begin
    oTGL  = (cnt_q == CW'(HDIV - 1));
    cnt_d = oTGL ? '0 : cnt_q + 1'b1;
    clk_d = clk_q ^ oTGL;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign oCLK = clk_q;
endmodule

// File: rtl/i2s_dac_tx.sv
// Stereo 16-bit I2S transmitter for the WM8731 (codec in slave mode): XCK, BCLK, LRCK, DACDAT.
// One-entry valid/ready buffer, drained once per 64-BCLK frame; an empty buffer replays the last pair.
module i2s_dac_tx
  import i2s_dac_tx_pkg::*;
#(
  parameter int MCLK_HDIV = 1,
  parameter int BCLK_HDIV = 4
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  input  logic [SAMPLE_W-1:0] iSAMPLE_L,
  input  logic [SAMPLE_W-1:0] iSAMPLE_R,
  input  logic                iVALID,
  output logic                oREADY,
  input  logic                iMUTE,
  output logic                oFRAME,
  output logic                oUNDERRUN,
  output logic                oAUD_XCK,
  output logic                oAUD_BCLK,
  output logic                oAUD_DACLRCK,
  output logic                oAUD_DACDAT
);
  logic xck, xck_tgl_unused, bclk, bclk_tgl;

  clk_half_div #(.HDIV(MCLK_HDIV)) u_xck_div (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .oCLK  (xck),
    .oTGL  (xck_tgl_unused)
  );

  clk_half_div #(.HDIV(BCLK_HDIV)) u_bclk_div (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .oCLK  (bclk),
    .oTGL  (bclk_tgl)
  );

  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d, cnt_nx;
  logic [SLOT_W-1:0] slot;
  logic              lrck_q, lrck_d, dat_q, dat_d, frame_q, frame_d;
  logic              underrun_q, underrun_d, buf_full_q, buf_full_d;
  stereo_t           buf_q, buf_d, sh_q, sh_d, last_q, last_d;
  logic              fall, load, accept;

  always_comb begin
    cnt_nx     = bit_cnt_q + 1'b1;
    slot       = cnt_nx[SLOT_W-1:0];
    fall       = bclk_tgl & bclk;
    load       = fall && (cnt_nx == '0);
    accept     = iVALID && !buf_full_q;
    bit_cnt_d  = bit_cnt_q;
    lrck_d     = lrck_q;
    dat_d      = dat_q;
    frame_d    = load;
    underrun_d = underrun_q;
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    sh_d       = sh_q;
    last_d     = last_q;

    // Data changes with the BCLK fall so the codec sees half a BCLK of setup.
    if (fall) begin
      bit_cnt_d = cnt_nx;
      lrck_d    = cnt_nx[CNT_W-1];
      dat_d     = 1'b0;
      if (load) begin
        if (buf_full_q) begin
          sh_d       = buf_q;
          last_d     = buf_q;
          buf_full_d = 1'b0;
        end else begin
          sh_d       = last_q;
          underrun_d = 1'b1;
        end
      end else if (slot != '0 && slot <= SLOT_W'(SAMPLE_W)) begin
        if (!cnt_nx[CNT_W-1]) begin
          dat_d  = sh_q.l[SAMPLE_W-1];
          sh_d.l = {sh_q.l[SAMPLE_W-2:0], 1'b0};
        end else begin
          dat_d  = sh_q.r[SAMPLE_W-1];
          sh_d.r = {sh_q.r[SAMPLE_W-2:0], 1'b0};
        end
      end
      if (iMUTE) dat_d = 1'b0;
    end

    // Accept only happens while empty, so it never collides with a draining load.
    if (accept) begin
      buf_d      = '{l: iSAMPLE_L, r: iSAMPLE_R};
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      bit_cnt_q  <= '0;
      lrck_q     <= 1'b0;
      dat_q      <= 1'b0;
      frame_q    <= 1'b0;
      underrun_q <= 1'b0;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      sh_q       <= '0;
      last_q     <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      lrck_q     <= lrck_d;
      dat_q      <= dat_d;
      frame_q    <= frame_d;
      underrun_q <= underrun_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      sh_q       <= sh_d;
      last_q     <= last_d;
    end
  end

  assign oREADY       = !buf_full_q;
  assign oFRAME       = frame_q;
  assign oUNDERRUN    = underrun_q;
  assign oAUD_XCK     = xck;
  assign oAUD_BCLK    = bclk;
  assign oAUD_DACLRCK = lrck_q;
  assign oAUD_DACDAT  = dat_q;
endmodule
